// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request outstanding to a
// variable-latency memory, and queues {instruction, pc+1} pairs for IF/ID.
module fetch_prefetch_unit #(
  parameter int ADDR_W   = 12,
  parameter int INSTR_W  = 19,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc_plus1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  // Set once a request has been issued since reset; responses seen in IDLE before
  // that are leftovers from a transaction abandoned by reset.
  logic               armed_q;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pcp1_q  [DEPTH];

  logic issue, push, pop;

  assign imem_addr       = fetch_pc_q;
  assign out_valid       = (count_q != '0);
  assign out_instruction = instr_q[rd_ptr_q];
  assign out_pc_plus1    = pcp1_q[rd_ptr_q];

  always_comb begin
    imem_req   = 1'b0;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // Requests only go out with a free slot reserved, so a later push never overflows.
    if (state_q == S_IDLE) imem_req = rst && (count_q < DEPTH_C) && !redirect;
    issue = imem_req && imem_ready;
    push  = (state_q == S_WAIT) && imem_valid && !redirect;
    pop   = out_valid && id_ready && !redirect;

    unique case (state_q)
      S_IDLE:    if (issue) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_valid)    state_d = S_IDLE;
        else if (redirect) state_d = S_DISCARD;
      end
      S_DISCARD: if (imem_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC_C;
      req_pc_q   <= RESET_PC_C;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (issue) armed_q <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          instr_q[gi] <= '0;
          pcp1_q[gi]  <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          instr_q[gi] <= imem_data;
          pcp1_q[gi]  <= req_pc_q + ADDR_W'(1);
        end
      end
    end
  endgenerate

  stray_valid_a: assert property (@(posedge clk) disable iff (!rst)
    !(imem_valid && armed_q && (state_q == S_IDLE)))
    else $error("imem_valid with no outstanding request");

endmodule
